// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives start and operands; the slave returns status and the held result.
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first, one full-subtractor cell; ovf logic under SERIAL_SUBTRACTOR_OVF_EN.
// Latency: WIDTH clocks from the start-accept edge to the edge raising done.
// Backpressure: none; start is ignored while busy, results hold until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic accept;
  logic last;
  logic d_bit;
  logic br_nxt;

  assign accept = (state == IDLE) && bus.start;
  assign last   = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

  // Single full-subtractor cell fed by the operand LSBs and the registered borrow.
  assign d_bit  = a_sh[0] ^ b_sh[0] ^ br;
  assign br_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      done_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        a_sh <= bus.a;
        b_sh <= bus.b;
        br   <= bus.bin;
        cnt  <= '0;
      end else if (state == SHIFT) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        res_sh <= {d_bit, res_sh[WIDTH-1:1]};
        br     <= br_nxt;
        cnt    <= cnt + 1'b1;
        if (last) begin
          diff_q <= {d_bit, res_sh[WIDTH-1:1]};
          bout_q <= br_nxt;
        end
      end
    end
  end

  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  // Operand MSBs are shifted out during the run, so keep copies for the overflow test.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) begin
        a_msb <= bus.a[WIDTH-1];
        b_msb <= bus.b[WIDTH-1];
      end
      if (last) ovf_q <= (a_msb != b_msb) && (d_bit != a_msb);
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial full subtractor. It is the inverse-operation companion to the team's combinational full adder built from half-adder cells.
- Loads two WIDTH-bit operands and a borrow-in on a start strobe.
- Computes A - B - Bin LSB-first, one bit per clock, through a single full-subtractor cell plus a registered borrow.
- Returns the difference, borrow-out and a one-cycle done pulse. Intended for board demos driven by switches/keys, with results shown on LEDs.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  minuend, captured on accepted start.
- b  input  WIDTH  subtrahend, captured on accepted start.
- bin  input  1  borrow-in, captured on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse: diff/bout/ovf valid.
- diff  output  WIDTH  difference, held until the next completion.
- bout  output  1  borrow-out of the MSB, held.
- ovf  output  1  signed overflow flag (see Optional Feature), held.

Behaviour:
- Reset (rst=1 at an edge) clears busy, done, diff, bout, ovf, the operand shift registers, the borrow register and the bit counter, and returns the FSM to IDLE. Reset wins over every other input.
- FSM states:
  - IDLE: busy=0.
  - SHIFT: busy=1.
- IDLE -> SHIFT: start=1 at an edge (edge E0).
  - Loads a_sh<=a, b_sh<=b, br<=bin, cnt<=0.
  - Outputs diff/bout/ovf keep their old values.
- SHIFT, each edge Ek (k=1..WIDTH) processes bit k-1:
  - d = a_sh[0] ^ b_sh[0] ^ br.
  - br <= (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br).
  - a_sh and b_sh shift right by one.
  - d shifts into the MSB of the result shift register.
  - cnt increments.
- SHIFT -> IDLE at edge E(WIDTH), i.e. when cnt = WIDTH-1 before the edge. At that edge:
  - diff is loaded from the completed result register.
  - bout = final borrow.
  - done <= 1, busy <= 0.
- done is high for exactly one cycle after E(WIDTH). Latency is WIDTH clocks from the edge that accepts start to the edge that raises done.
- Arithmetic: {bout,diff} = (A - B - Bin) mod 2^(WIDTH+1), with bout=1 iff A < B+Bin, treating A and B as unsigned.
- start while busy=1: ignored; operands and progress are unaffected.
- start=1 in the cycle where done=1: accepted (FSM is IDLE). done drops next cycle and busy rises. diff holds its old value until the new completion.
- a/b/bin changing while busy: no effect.
- rst asserted mid-operation: aborts; all outputs return to reset values at that edge. No done is issued.
- start held high continuously: a new operation starts every WIDTH+1... precisely, each time IDLE is re-entered, with back-to-back restarts on each done cycle.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined: at completion, ovf <= a_msb_captured ^ b_msb_captured ^ ... computed as (A[W-1] != B[W-1]) && (diff[W-1] != A[W-1]). This is two's-complement overflow of A - B - Bin. It is held alongside diff and cleared on reset.
- Not defined: ovf is constant 0, no overflow logic is synthesised, and the port remains present.

Test Plan:
- WIDTH=8, rst pulse then start with a=0x5A, b=0x3C, bin=0 -> busy high for 8 cycles; done pulses 8 clocks after start edge; diff=0x1E, bout=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
- Start a=0x33,b=0x11; pulse start again at clock 3 with a=0xFF,b=0x00 -> second start ignored; diff=0x22, done exactly once.
- Start, then rst=1 at clock 4 -> busy=0, diff=0x00, bout=0, no done pulse; new start afterwards completes correctly.
- start held high with a=0x09,b=0x04 -> done every 9 clocks, each with diff=0x05; busy low only on done cycles.
- With SERIAL_SUBTRACTOR_OVF_EN: a=0x80,b=0x01 -> diff=0x7F, ovf=1; a=0x05,b=0x03 -> ovf=0. Without the macro: ovf=0 in both cases.
